// File: rtl/jtag_tap_master.sv
// JTAG TAP master: walks the TAP through INIT, then one IR or DR
// scan per command, returning captured TDO bits on a response pulse.
module jtag_tap_master #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_ir,
  input  logic [5:0]  cmd_len,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  typedef enum logic [2:0] {
    INIT, IDLE, SEL, CAP, SHIFT, EXIT, UPD, DONE
  } state_t;

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  state_t      state, state_d;
  logic [6:0]  cnt, cnt_d, cnt_nxt, len7, last;
  logic [7:0]  div;
  logic        tms_d, tdi_d;
  logic        ir_q;
  logic [5:0]  len_q;
  logic [63:0] data_q, cap;
  logic        run, half_end, fall, rise, accept;

  assign run       = (state != IDLE) && (state != DONE);
  assign half_end  = run && (div == DIV_MAX);
  assign fall      = half_end && tck;
  assign rise      = half_end && !tck;
  assign cmd_ready = (state == IDLE) || (state == DONE);
  assign rsp_valid = (state == DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign len7      = (len_q == 6'd0) ? 7'd64 : {1'b0, len_q};
  assign last      = len7 - 7'd1;
  assign cnt_nxt   = cnt + 7'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_d;
  end

  // Each transition fires on a falling tck edge and sets up
  // tms/tdi for the pulse that edge begins.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    tms_d   = tms;
    tdi_d   = tdi;
    unique case (state)
      INIT: if (fall) begin
        if (cnt == 7'd5) begin
          state_d = IDLE;
          cnt_d   = '0;
          tms_d   = 1'b0;
        end else begin
          cnt_d = cnt_nxt;
          tms_d = (cnt != 7'd4);
        end
      end
      IDLE, DONE: begin
        if (accept) begin
          state_d = SEL;
          cnt_d   = '0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
        end else if (state == DONE) begin
          state_d = IDLE;
        end
      end
      SEL: if (fall) begin
        if (ir_q && cnt == 7'd0) begin
          cnt_d = 7'd1;
        end else begin
          state_d = CAP;
          cnt_d   = '0;
          tms_d   = 1'b0;
        end
      end
      CAP: if (fall) begin
        if (cnt == 7'd0) begin
          cnt_d = 7'd1;
        end else begin
          state_d = SHIFT;
          cnt_d   = '0;
          tms_d   = (last == 7'd0);
          tdi_d   = data_q[0];
        end
      end
      SHIFT: if (fall) begin
        if (cnt == last) begin
          state_d = EXIT;
          cnt_d   = '0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
        end else begin
          cnt_d = cnt_nxt;
          tms_d = (cnt_nxt == last);
          tdi_d = data_q[cnt_nxt[5:0]];
        end
      end
      EXIT: if (fall) begin
        state_d = UPD;
        tms_d   = 1'b0;
      end
      UPD: if (fall) begin
        state_d = DONE;
        tms_d   = 1'b0;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div      <= '0;
      tck      <= 1'b0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
      ir_q     <= 1'b0;
      len_q    <= '0;
      data_q   <= '0;
      cap      <= '0;
      rsp_data <= '0;
    end else begin
      cnt <= cnt_d;
      tms <= tms_d;
      tdi <= tdi_d;
      if (!run) begin
        div <= '0;
        tck <= 1'b0;
      end else if (div == DIV_MAX) begin
        div <= '0;
        tck <= ~tck;
      end else begin
        div <= div + 8'd1;
      end
      if (accept) begin
        ir_q   <= cmd_ir;
        len_q  <= cmd_len;
        data_q <= cmd_data;
        cap    <= '0;
      end
      if (rise && state == SHIFT) cap[cnt[5:0]] <= tdo;
      if (fall && state == UPD)   rsp_data <= cap;
    end
  end

endmodule
